// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Per-register pending tracker that sits beside decode. Each architectural
// register r>=1 carries a pending flag and a down-counter holding the cycles
// left until its in-flight result becomes bypassable. Decode sources are
// checked against this table to produce the RAW/WAW stall, the issue-fire
// strobe and the operand bypass selects. Register 0 is hard-wired zero and is
// never pending.
//
// Optional build macro: HAZARD_SCOREBOARD_PERF_EN adds two saturating 32-bit
// counters, stall_cnt_o (all stall cycles) and raw_cnt_o (RAW-caused stall
// cycles). With the macro undefined those ports do not exist.
//
// Ports:
//   clk                  core clock
//   rst                  asynchronous active-high reset
//   issue_valid_i        decode holds a valid instruction
//   issue_rd_i           destination register
//   issue_we_i           instruction writes rd
//   issue_lat_i          cycles until the result is bypassable (0 = next cycle)
//   issue_rs1_i/rs2_i    source registers
//   issue_rs1/2_used_i   source actually read
//   flush_i              squash the instruction in decode
//   wb_valid_i           writeback commits this cycle
//   wb_rd_i              register being committed
//   stall_o              hold PC and IF/DE
//   issue_fire_o         instruction leaves decode this cycle
//   fwd_a_o / fwd_b_o    operand select: 00 regfile, 10 bypass
//   busy_o               registered pending-register bitmap
//   stall_cnt_o          (PERF_EN) stall cycle count
//   raw_cnt_o            (PERF_EN) RAW stall cycle count

module hazard_scoreboard #(
   parameter int NREGS   = 8,
   parameter int LAT_MAX = 3,
   parameter int AW      = $clog2(NREGS),
   parameter int LW      = $clog2(LAT_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid_i,
   input  logic [AW-1:0]    issue_rd_i,
   input  logic             issue_we_i,
   input  logic [LW-1:0]    issue_lat_i,
   input  logic [AW-1:0]    issue_rs1_i,
   input  logic [AW-1:0]    issue_rs2_i,
   input  logic             issue_rs1_used_i,
   input  logic             issue_rs2_used_i,
   input  logic             flush_i,
   input  logic             wb_valid_i,
   input  logic [AW-1:0]    wb_rd_i,
   output logic             stall_o,
   output logic             issue_fire_o,
   output logic [1:0]       fwd_a_o,
   output logic [1:0]       fwd_b_o,
   output logic [NREGS-1:0] busy_o
`ifdef HAZARD_SCOREBOARD_PERF_EN
   ,
   output logic [31:0]      stall_cnt_o,
   output logic [31:0]      raw_cnt_o
`endif
);

   localparam logic [LW-1:0] LAT_MAX_LW = LW'(LAT_MAX);

   logic [NREGS-1:0] pending;
   logic [LW-1:0]    cnt [NREGS];

   logic [LW-1:0]    lat_sat;
   logic             haz_a;
   logic             haz_b;
   logic             raw_a;
   logic             raw_b;
   logic             byp_a;
   logic             byp_b;
   logic             waw;
   logic             raw_any;

   // Out-of-range latencies clamp so the counter never exceeds LAT_MAX.
   assign lat_sat = (issue_lat_i > LAT_MAX_LW) ? LAT_MAX_LW : issue_lat_i;

   assign haz_a = issue_rs1_used_i && (issue_rs1_i != '0) && pending[issue_rs1_i];
   assign haz_b = issue_rs2_used_i && (issue_rs2_i != '0) && pending[issue_rs2_i];

   assign raw_a = haz_a && (cnt[issue_rs1_i] != '0);
   assign raw_b = haz_b && (cnt[issue_rs2_i] != '0);
   assign byp_a = haz_a && (cnt[issue_rs1_i] == '0);
   assign byp_b = haz_b && (cnt[issue_rs2_i] == '0);

   // An older result still further away than the new one would land after it
   // and clobber the younger value.
   assign waw = issue_we_i && (issue_rd_i != '0) && pending[issue_rd_i] &&
                (cnt[issue_rd_i] > lat_sat);

   assign raw_any = raw_a | raw_b;

   // Gating with rst keeps the strobes quiet while the table is being cleared.
   assign stall_o      = ~rst & issue_valid_i & (raw_any | waw) & ~flush_i;
   assign issue_fire_o = ~rst & issue_valid_i & ~stall_o & ~flush_i;

   assign fwd_a_o = byp_a ? 2'b10 : 2'b00;
   assign fwd_b_o = byp_b ? 2'b10 : 2'b00;

   assign busy_o = pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         for (int r = 0; r < NREGS; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         pending[0] <= 1'b0;
         cnt[0]     <= '0;
         for (int r = 1; r < NREGS; r++) begin
            // A same-cycle fire to the register beats its writeback.
            if (issue_fire_o && issue_we_i && (issue_rd_i == AW'(r))) begin
               pending[r] <= 1'b1;
               cnt[r]     <= lat_sat;
            end else if (wb_valid_i && (wb_rd_i == AW'(r))) begin
               pending[r] <= 1'b0;
               cnt[r]     <= '0;
            end else if (pending[r] && (cnt[r] != '0)) begin
               cnt[r] <= cnt[r] - 1'b1;
            end
         end
      end
   end

`ifdef HAZARD_SCOREBOARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_o <= '0;
         raw_cnt_o   <= '0;
      end else begin
         if (stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
         if (stall_o && raw_any && (raw_cnt_o != '1)) begin
            raw_cnt_o <= raw_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

   localparam int NREGS   = 8;
   localparam int LAT_MAX = 3;
   localparam int AW      = 3;
   localparam int LW      = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             issue_valid_i;
   logic [AW-1:0]    issue_rd_i;
   logic             issue_we_i;
   logic [LW-1:0]    issue_lat_i;
   logic [AW-1:0]    issue_rs1_i;
   logic [AW-1:0]    issue_rs2_i;
   logic             issue_rs1_used_i;
   logic             issue_rs2_used_i;
   logic             flush_i;
   logic             wb_valid_i;
   logic [AW-1:0]    wb_rd_i;
   logic             stall_o;
   logic             issue_fire_o;
   logic [1:0]       fwd_a_o;
   logic [1:0]       fwd_b_o;
   logic [NREGS-1:0] busy_o;
`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [31:0]      stall_cnt_o;
   logic [31:0]      raw_cnt_o;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NREGS(NREGS), .LAT_MAX(LAT_MAX)) dut (
      .clk              (clk),
      .rst              (rst),
      .issue_valid_i    (issue_valid_i),
      .issue_rd_i       (issue_rd_i),
      .issue_we_i       (issue_we_i),
      .issue_lat_i      (issue_lat_i),
      .issue_rs1_i      (issue_rs1_i),
      .issue_rs2_i      (issue_rs2_i),
      .issue_rs1_used_i (issue_rs1_used_i),
      .issue_rs2_used_i (issue_rs2_used_i),
      .flush_i          (flush_i),
      .wb_valid_i       (wb_valid_i),
      .wb_rd_i          (wb_rd_i),
      .stall_o          (stall_o),
      .issue_fire_o     (issue_fire_o),
      .fwd_a_o          (fwd_a_o),
      .fwd_b_o          (fwd_b_o),
      .busy_o           (busy_o)
`ifdef HAZARD_SCOREBOARD_PERF_EN
      ,
      .stall_cnt_o      (stall_cnt_o),
      .raw_cnt_o        (raw_cnt_o)
`endif
   );

   // Reference model: each pending register remembers the absolute cycle at
   // which its result becomes bypassable; remaining latency is derived from
   // the current cycle number.
   bit         m_pend [NREGS];
   int         m_ready [NREGS];
   int         m_now;
   logic       exp_stall;
   logic       exp_fire;
   logic       exp_raw_stall;
   logic [1:0] exp_fwd_a;
   logic [1:0] exp_fwd_b;
   int         m_stall_cnt;
   int         m_raw_cnt;

   function automatic int m_left(input int r);
      if (!m_pend[r]) return 0;
      return (m_ready[r] > m_now) ? m_ready[r] - m_now : 0;
   endfunction

   function automatic int sat_lat(input int l);
      return (l > LAT_MAX) ? LAT_MAX : l;
   endfunction

   function automatic logic [NREGS-1:0] m_busy();
      logic [NREGS-1:0] b;
      for (int r = 0; r < NREGS; r++) b[r] = m_pend[r];
      return b;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < NREGS; r++) begin
         m_pend[r]  = 1'b0;
         m_ready[r] = 0;
      end
      m_now       = 0;
      m_stall_cnt = 0;
      m_raw_cnt   = 0;
   endtask

   task automatic model_eval();
      bit h1, h2, r1, r2, waw;
      h1  = issue_rs1_used_i && issue_rs1_i != 0 && m_pend[issue_rs1_i];
      h2  = issue_rs2_used_i && issue_rs2_i != 0 && m_pend[issue_rs2_i];
      r1  = h1 && m_left(int'(issue_rs1_i)) > 0;
      r2  = h2 && m_left(int'(issue_rs2_i)) > 0;
      waw = issue_we_i && issue_rd_i != 0 && m_pend[issue_rd_i] &&
            m_left(int'(issue_rd_i)) > sat_lat(int'(issue_lat_i));
      exp_stall     = !rst && issue_valid_i && (r1 || r2 || waw) && !flush_i;
      exp_raw_stall = exp_stall && (r1 || r2);
      exp_fire      = !rst && issue_valid_i && !exp_stall && !flush_i;
      exp_fwd_a     = (h1 && !r1) ? 2'b10 : 2'b00;
      exp_fwd_b     = (h2 && !r2) ? 2'b10 : 2'b00;
   endtask

   // Advance one clock: the model absorbs the inputs held across the edge.
   task automatic tick();
      model_eval();
      @(posedge clk);
      if (!rst) begin
         if (wb_valid_i && wb_rd_i != 0) m_pend[wb_rd_i] = 1'b0;
         if (exp_fire && issue_we_i && issue_rd_i != 0) begin
            m_pend[issue_rd_i]  = 1'b1;
            m_ready[issue_rd_i] = m_now + 1 + sat_lat(int'(issue_lat_i));
         end
         if (exp_stall) m_stall_cnt++;
         if (exp_raw_stall) m_raw_cnt++;
         m_now++;
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] rd, input logic we,
                        input logic [LW-1:0] lat, input logic [AW-1:0] r1,
                        input logic u1, input logic [AW-1:0] r2, input logic u2,
                        input logic fl, input logic wv, input logic [AW-1:0] wr);
      issue_valid_i    = v;
      issue_rd_i       = rd;
      issue_we_i       = we;
      issue_lat_i      = lat;
      issue_rs1_i      = r1;
      issue_rs1_used_i = u1;
      issue_rs2_i      = r2;
      issue_rs2_used_i = u2;
      flush_i          = fl;
      wb_valid_i       = wv;
      wb_rd_i          = wr;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_clear();
      drive(1, 1, 1, 2, 1, 1, 1, 1, 0, 0, 0);
      #2;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL reset_stall: got %0b expected 0", stall_o);
      end
      checks++;
      if (issue_fire_o !== 1'b0) begin
         errors++; $display("FAIL reset_fire: got %0b expected 0", issue_fire_o);
      end
      checks++;
      if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin
         errors++; $display("FAIL reset_fwd: got %b/%b expected 00/00", fwd_a_o, fwd_b_o);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy_o !== '0) begin
         errors++; $display("FAIL reset_busy: got %b expected 0", busy_o);
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_alu_back_to_back();
      do_reset();
      drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      checks++;
      if (issue_fire_o !== 1'b1) begin
         errors++; $display("FAIL alu_producer_fire: got %0b expected 1", issue_fire_o);
      end
      tick();
      checks++;
      if (busy_o !== 8'b0000_1000) begin
         errors++; $display("FAIL alu_busy: got %b expected 00001000", busy_o);
      end
      drive(1, 6, 1, 0, 3, 1, 0, 0, 0, 0, 0);
      #4;
      checks++;
      if (stall_o !== 1'b0 || fwd_a_o !== 2'b10 || issue_fire_o !== 1'b1) begin
         errors++;
         $display("FAIL alu_dependent: got stall=%0b fwd_a=%b fire=%0b expected 0/10/1",
                  stall_o, fwd_a_o, issue_fire_o);
      end
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
      #4;
      checks++;
      if (stall_o !== 1'b1 || issue_fire_o !== 1'b0 || fwd_b_o !== 2'b00) begin
         errors++;
         $display("FAIL load_use_stall: got stall=%0b fire=%0b fwd_b=%b expected 1/0/00",
                  stall_o, issue_fire_o, fwd_b_o);
      end
      tick();
      #4;
      checks++;
      if (stall_o !== 1'b0 || issue_fire_o !== 1'b1 || fwd_b_o !== 2'b10) begin
         errors++;
         $display("FAIL load_use_bypass: got stall=%0b fire=%0b fwd_b=%b expected 0/1/10",
                  stall_o, issue_fire_o, fwd_b_o);
      end
      tick();
   endtask

   task automatic test_reg_zero();
      do_reset();
      drive(1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (busy_o !== '0) begin
         errors++; $display("FAIL zero_busy: got %b expected 0", busy_o);
      end
      drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      #4;
      checks++;
      if (stall_o !== 1'b0 || fwd_a_o !== 2'b00 || issue_fire_o !== 1'b1) begin
         errors++;
         $display("FAIL zero_source: got stall=%0b fwd_a=%b fire=%0b expected 0/00/1",
                  stall_o, fwd_a_o, issue_fire_o);
      end
      tick();
   endtask

   task automatic test_waw();
      do_reset();
      drive(1, 4, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #4;
         checks++;
         if (stall_o !== 1'b1 || issue_fire_o !== 1'b0) begin
            errors++;
            $display("FAIL waw_stall_%0d: got stall=%0b fire=%0b expected 1/0",
                     i, stall_o, issue_fire_o);
         end
         tick();
      end
      #4;
      checks++;
      if (stall_o !== 1'b0 || issue_fire_o !== 1'b1) begin
         errors++;
         $display("FAIL waw_release: got stall=%0b fire=%0b expected 0/1", stall_o, issue_fire_o);
      end
      tick();
      checks++;
      if (busy_o[4] !== 1'b1) begin
         errors++; $display("FAIL waw_busy: got %0b expected 1", busy_o[4]);
      end
      drive(1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0);
      #4;
      checks++;
      if (stall_o !== 1'b0 || fwd_a_o !== 2'b10) begin
         errors++;
         $display("FAIL waw_cnt_zero: got stall=%0b fwd_a=%b expected 0/10", stall_o, fwd_a_o);
      end
      tick();
   endtask

   task automatic test_wb_reissue_flush();
      do_reset();
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 5, 1, 2, 0, 0, 0, 0, 0, 1, 5);
      #4;
      checks++;
      if (issue_fire_o !== 1'b1) begin
         errors++; $display("FAIL reissue_fire: got %0b expected 1", issue_fire_o);
      end
      tick();
      checks++;
      if (busy_o !== 8'b0010_0000) begin
         errors++; $display("FAIL reissue_busy: got %b expected 00100000", busy_o);
      end
      // Hazarding instruction squashed by a redirect.
      drive(1, 6, 1, 0, 5, 1, 0, 0, 1, 0, 0);
      #4;
      checks++;
      if (stall_o !== 1'b0 || issue_fire_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_outputs: got stall=%0b fire=%0b expected 0/0", stall_o, issue_fire_o);
      end
      tick();
      checks++;
      if (busy_o !== 8'b0010_0000) begin
         errors++; $display("FAIL flush_state: got %b expected 00100000", busy_o);
      end
      drive(1, 0, 0, 0, 5, 1, 5, 1, 0, 0, 0);
      #4;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++; $display("FAIL reissue_cnt_stall: got %0b expected 1", stall_o);
      end
      tick();
      #4;
      checks++;
      if (stall_o !== 1'b0 || fwd_a_o !== 2'b10 || fwd_b_o !== 2'b10 || issue_fire_o !== 1'b1) begin
         errors++;
         $display("FAIL reissue_both_bypass: got stall=%0b fwd=%b/%b fire=%0b expected 0/10/10/1",
                  stall_o, fwd_a_o, fwd_b_o, issue_fire_o);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
      tick();
      drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      #4;
      checks++;
      if (fwd_a_o !== 2'b00 || busy_o[5] !== 1'b0) begin
         errors++;
         $display("FAIL after_wb: got fwd_a=%b busy5=%0b expected 00/0", fwd_a_o, busy_o[5]);
      end
      tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (busy_o !== 8'b0000_1110) begin
         errors++; $display("FAIL async_pre_busy: got %b expected 00001110", busy_o);
      end
      #2;
      rst = 1'b1;
      model_clear();
      #1;
      checks++;
      if (busy_o !== '0) begin
         errors++; $display("FAIL async_busy: got %b expected 0", busy_o);
      end
      rst = 1'b0;
      drive(1, 0, 0, 0, 1, 1, 2, 1, 0, 0, 0);
      #1;
      checks++;
      if (stall_o !== 1'b0 || fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00 || issue_fire_o !== 1'b1) begin
         errors++;
         $display("FAIL async_first_issue: got stall=%0b fwd=%b/%b fire=%0b expected 0/00/00/1",
                  stall_o, fwd_a_o, fwd_b_o, issue_fire_o);
      end
      tick();
   endtask

`ifdef HAZARD_SCOREBOARD_PERF_EN
   task automatic test_perf();
      do_reset();
      drive(1, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 3, 1, 2, 2, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick();
      drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (stall_cnt_o !== 32'd5) begin
         errors++; $display("FAIL perf_stall_cnt: got %0d expected 5", stall_cnt_o);
      end
      checks++;
      if (raw_cnt_o !== 32'd5) begin
         errors++; $display("FAIL perf_raw_cnt: got %0d expected 5", raw_cnt_o);
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 800; n++) begin
         drive(($urandom_range(0, 9) < 8), AW'($urandom_range(0, NREGS - 1)),
               ($urandom_range(0, 9) < 7), LW'($urandom_range(0, LAT_MAX)),
               AW'($urandom_range(0, NREGS - 1)), ($urandom_range(0, 9) < 7),
               AW'($urandom_range(0, NREGS - 1)), ($urandom_range(0, 9) < 5),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3),
               AW'($urandom_range(0, NREGS - 1)));
         #4;
         model_eval();
         checks++;
         if (stall_o !== exp_stall) begin
            errors++; $display("FAIL rnd_stall@%0d: got %0b expected %0b", n, stall_o, exp_stall);
         end
         checks++;
         if (issue_fire_o !== exp_fire) begin
            errors++; $display("FAIL rnd_fire@%0d: got %0b expected %0b", n, issue_fire_o, exp_fire);
         end
         checks++;
         if (fwd_a_o !== exp_fwd_a || fwd_b_o !== exp_fwd_b) begin
            errors++;
            $display("FAIL rnd_fwd@%0d: got %b/%b expected %b/%b",
                     n, fwd_a_o, fwd_b_o, exp_fwd_a, exp_fwd_b);
         end
         tick();
         checks++;
         if (busy_o !== m_busy()) begin
            errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", n, busy_o, m_busy());
         end
`ifdef HAZARD_SCOREBOARD_PERF_EN
         checks++;
         if (stall_cnt_o !== 32'(m_stall_cnt) || raw_cnt_o !== 32'(m_raw_cnt)) begin
            errors++;
            $display("FAIL rnd_perf@%0d: got %0d/%0d expected %0d/%0d",
                     n, stall_cnt_o, raw_cnt_o, m_stall_cnt, m_raw_cnt);
         end
`endif
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_clear();
      @(posedge clk);
      #1;
      test_reset();
      test_alu_back_to_back();
      test_load_use();
      test_reg_zero();
      test_waw();
      test_wb_reissue_flush();
      test_async_reset();
`ifdef HAZARD_SCOREBOARD_PERF_EN
      test_perf();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
